step0_ctrl: RTL and testbench

//  Sequencer for FFT stage 0 (512-pt radix-2 DIF, 16 lanes/beat, 32 beats/frame).

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/step0_ctrl.sv | 173 +++++++++++++++++
 tb/tb_step0_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants and types for the 512-point radix-2 DIF FFT.
//                Holds the frame geometry used by the stage-0 sequencer, the
//                FILL/BFLY phase encoding and the output-mux control bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_pkg;

    // Frame geometry: 512 samples carried 16 lanes per beat.
    localparam int unsigned N_FFT    = 512;
    localparam int unsigned LANES    = 16;
    // Beats per half-frame (256 samples / 16 lanes).
    localparam int unsigned BLK_HALF = N_FFT / 2 / LANES;
    // Beat counter width covering one whole frame.
    localparam int unsigned CNT_W    = $clog2(2 * BLK_HALF);
    // Sub-result buffer / twiddle-block index width.
    localparam int unsigned ADDR_W   = CNT_W - 1;

    // Stage-0 phase: first half-frame only fills the shift register,
    // second half-frame combines with the delayed first half.
    typedef enum logic {
        FILL = 1'b0,
        BFLY = 1'b1
    } step0_phase_e;

    // Control bundle travelling with each beat handed to step1.
    typedef struct packed {
        logic              out_valid;
        logic              out_sel;    // 0 = live add path, 1 = drained sub path
        logic [ADDR_W-1:0] tw_idx;     // twiddle block for sub beats, 0 otherwise
    } step0_omux_t;

    // True when an index addresses the final entry of a half-frame.
    function automatic logic is_last_idx(input logic [ADDR_W-1:0] idx);
        return idx == ADDR_W'(BLK_HALF - 1);
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/step0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : step0_ctrl
//  Description : Sequencer for FFT stage 0 (512-pt radix-2 DIF, 16 lanes per
//                beat, 32 beats per frame). Counts input beats, separates the
//                shift-register fill half from the butterfly half, addresses
//                the 16-entry sub-result buffer and interleaves live add beats
//                with drained sub beats onto a single stream for step1.
//  Ports       : clk, rstn (async active-low)
//                din_valid            - one 16-lane beat this cycle
//                sr_shift, bf_en      - combinational shift / combine enables
//                sub_wr, sub_wr_addr  - sub-result buffer write (registered)
//                sub_rd, sub_rd_addr  - sub-result buffer read  (registered)
//                out_valid, out_sel,
//                tw_idx               - step1 output-mux control (registered)
//                frame_done           - pulse with the last drained sub beat
//                busy                 - frame in progress or drain active
//  Options     : STEP0_SOF_EN adds din_sof (start-of-frame, qualified by
//                din_valid) and sync_err (1-cycle pulse on a misaligned SOF).
//  Revision    : 1.0  initial release
// ============================================================================
module step0_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned BLK_HALF = fft_pkg::BLK_HALF,
    parameter int unsigned CNT_W    = fft_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               din_valid,
`ifdef STEP0_SOF_EN
    input  logic               din_sof,
    output logic               sync_err,
`endif
    output logic               sr_shift,
    output logic               bf_en,
    output logic               sub_wr,
    output logic [CNT_W-2:0]   sub_wr_addr,
    output logic               sub_rd,
    output logic [CNT_W-2:0]   sub_rd_addr,
    output logic               out_valid,
    output logic               out_sel,
    output logic [CNT_W-2:0]   tw_idx,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned AW = CNT_W - 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_drain_act;
    logic [AW-1:0]    r_drain_cnt;
    logic             r_sub_wr;
    logic [AW-1:0]    r_sub_wr_addr;
    step0_omux_t      r_omux;
    logic             r_frame_done;
`ifdef STEP0_SOF_EN
    logic             r_sync_err;
`endif

    // ------------------------------------------------------------------
    // Beat decode
    // ------------------------------------------------------------------
    logic             w_sof_beat;
    logic [CNT_W-1:0] w_cnt_eff;
    step0_phase_e     w_phase;
    logic             w_bf_en;
    logic             w_last_beat;

`ifdef STEP0_SOF_EN
    assign w_sof_beat = din_valid & din_sof;
`else
    assign w_sof_beat = 1'b0;
`endif

    // A start-of-frame beat is always beat 0, whatever the counter says.
    // This also drops any partial frame: its remaining BFLY beats are never
    // reached and its drain never starts.
    assign w_cnt_eff   = w_sof_beat ? '0 : r_beat_cnt;
    assign w_phase     = step0_phase_e'(w_cnt_eff[CNT_W-1]);
    assign w_bf_en     = din_valid & (w_phase == BFLY);
    assign w_last_beat = w_bf_en & (w_cnt_eff == CNT_W'(2 * BLK_HALF - 1));

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt    <= '0;
            r_drain_act   <= 1'b0;
            r_drain_cnt   <= '0;
            r_sub_wr      <= 1'b0;
            r_sub_wr_addr <= '0;
            r_omux        <= '0;
            r_frame_done  <= 1'b0;
`ifdef STEP0_SOF_EN
            r_sync_err    <= 1'b0;
`endif
        end else begin
            // Counter only moves on accepted beats; gaps freeze it.
            if (din_valid) begin
                r_beat_cnt <= w_cnt_eff + 1'b1;
            end

            // Butterfly results are registered, so the sub write lands one
            // cycle after the combine, together with the add beat.
            r_sub_wr <= w_bf_en;
            if (w_bf_en) begin
                r_sub_wr_addr <= w_cnt_eff[AW-1:0];
            end

            // Drain runs freely for one half-frame once the last BFLY beat
            // is in, regardless of din_valid.
            if (w_last_beat) begin
                r_drain_act <= 1'b1;
                r_drain_cnt <= '0;
            end else if (r_drain_act) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
                if (is_last_idx(r_drain_cnt)) begin
                    r_drain_act <= 1'b0;
                end
            end

            // Output mux: read data appears the cycle after sub_rd. The
            // next frame's FILL half keeps add beats away from the drain.
            if (w_bf_en) begin
                r_omux.out_valid <= 1'b1;
                r_omux.out_sel   <= 1'b0;
                r_omux.tw_idx    <= '0;
            end else if (r_drain_act) begin
                r_omux.out_valid <= 1'b1;
                r_omux.out_sel   <= 1'b1;
                r_omux.tw_idx    <= r_drain_cnt;
            end else begin
                r_omux           <= '0;
            end

            r_frame_done <= ~w_bf_en & r_drain_act & is_last_idx(r_drain_cnt);

`ifdef STEP0_SOF_EN
            r_sync_err <= w_sof_beat & (r_beat_cnt != '0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sr_shift    = din_valid;
    assign bf_en       = w_bf_en;
    assign sub_wr      = r_sub_wr;
    assign sub_wr_addr = r_sub_wr_addr;
    assign sub_rd      = r_drain_act;
    assign sub_rd_addr = r_drain_cnt;
    assign out_valid   = r_omux.out_valid;
    assign out_sel     = r_omux.out_sel;
    assign tw_idx      = r_omux.tw_idx;
    assign frame_done  = r_frame_done;
    assign busy        = (r_beat_cnt != '0) | r_drain_act;
`ifdef STEP0_SOF_EN
    assign sync_err    = r_sync_err;
`endif

    // An add beat and a sub read falling due together would lose data.
    a_no_collision : assert property (
        @(posedge clk) disable iff (!rstn) !(w_bf_en && r_drain_act)
    );

endmodule : step0_ctrl
`default_nettype wire

// File: tb/tb_step0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step0_ctrl
//  Description : Self-checking bench for step0_ctrl. A beat-count model pushes
//                expected output beats into a scoreboard as beats are driven;
//                a negedge monitor pops and compares them against the DUT.
//                Sections under STEP0_SOF_EN exercise din_sof / sync_err.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_step0_ctrl;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b1;
    logic       din_valid = 1'b0;
`ifdef STEP0_SOF_EN
    logic       din_sof   = 1'b0;
    logic       sync_err;
`endif
    logic       sr_shift;
    logic       bf_en;
    logic       sub_wr;
    logic [3:0] sub_wr_addr;
    logic       sub_rd;
    logic [3:0] sub_rd_addr;
    logic       out_valid;
    logic       out_sel;
    logic [3:0] tw_idx;
    logic       frame_done;
    logic       busy;

    step0_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .din_valid   (din_valid),
`ifdef STEP0_SOF_EN
        .din_sof     (din_sof),
        .sync_err    (sync_err),
`endif
        .sr_shift    (sr_shift),
        .bf_en       (bf_en),
        .sub_wr      (sub_wr),
        .sub_wr_addr (sub_wr_addr),
        .sub_rd      (sub_rd),
        .sub_rd_addr (sub_rd_addr),
        .out_valid   (out_valid),
        .out_sel     (out_sel),
        .tw_idx      (tw_idx),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       sel;
        logic [3:0] idx;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    int n_pass = 0;
    int n_total = 0;
    int m_cnt = 0;
    int m_rd_exp = 0;
    int n_out = 0;
    int n_add = 0;
    int n_sub = 0;
    int first_out_cyc = -1;
    int fd_cyc = -1;
    int sub0_cyc = -1;
    int last_tw = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Output monitor / scoreboard consumer
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (sub_rd) begin
                chk("sub_rd_addr", 32'(sub_rd_addr), 32'(m_rd_exp));
                m_rd_exp = (m_rd_exp + 1) % 16;
            end
            if (out_valid) begin
                n_out++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_sel", 32'(out_sel), 32'(e.sel));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    if (!e.sel) begin
                        n_add++;
                        chk("add_sub_wr", 32'(sub_wr), 1);
                        chk("sub_wr_addr", 32'(sub_wr_addr), 32'(e.idx));
                        chk("add_tw_idx", 32'(tw_idx), 0);
                    end else begin
                        n_sub++;
                        chk("tw_idx", 32'(tw_idx), 32'(e.idx));
                        last_tw = int'(tw_idx);
                        if (tw_idx == 4'd0) sub0_cyc = cyc;
                        if (frame_done) fd_cyc = cyc;
                    end
                end
            end else begin
                chk("idle_frame_done", 32'(frame_done), 0);
                chk("idle_sub_wr", 32'(sub_wr), 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input bit sof);
        int   c;
        bit   bf;
        bit   err_exp;
        exp_t e;
        err_exp   = sof && (m_cnt != 0);
        if (sof) m_cnt = 0;
        din_valid = 1'b1;
`ifdef STEP0_SOF_EN
        din_sof   = sof;
`endif
        c  = m_cnt;
        bf = (c >= 16);
        #1;
        chk("sr_shift", 32'(sr_shift), 1);
        chk("bf_en", 32'(bf_en), 32'(bf));
        if (bf) begin
            e.sel = 1'b0; e.idx = 4'(c - 16); e.fd = 1'b0;
            sb.push_back(e);
        end
        if (c == 31) begin
            for (int i = 0; i < 16; i++) begin
                e.sel = 1'b1; e.idx = 4'(i); e.fd = (i == 15);
                sb.push_back(e);
            end
        end
        m_cnt = (c + 1) % 32;
        tick();
        din_valid = 1'b0;
`ifdef STEP0_SOF_EN
        din_sof = 1'b0;
        chk("sync_err", 32'(sync_err), 32'(err_exp));
`else
        if (err_exp) chk("sof_unsupported", 32'(err_exp), 0);
`endif
    endtask

    task automatic idle();
        din_valid = 1'b0;
        #1;
        chk("idle_bf_en", 32'(bf_en), 0);
        tick();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        din_valid = 1'b0;
        sb.delete();
        m_cnt     = 0;
        m_rd_exp  = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_tw_idx", 32'(tw_idx), 0);
        chk("rst_sub_wr", 32'(sub_wr), 0);
        chk("rst_sub_wr_addr", 32'(sub_wr_addr), 0);
        chk("rst_sub_rd", 32'(sub_rd), 0);
        chk("rst_sub_rd_addr", 32'(sub_rd_addr), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int base;
        int base2;
        int fd_before;

        #2;
        do_reset();

        // T1: reset mid-frame at beat 20, then one clean frame
        repeat (20) drive_beat(1'b0);
        chk("t1_busy_mid", 32'(busy), 1);
        din_valid = 1'b1;
        #1;
        do_reset();
        first_out_cyc = -1;
        c0 = cyc;
        repeat (32) drive_beat(1'b0);
        repeat (20) idle();
        chk("t1_first_add_lat", 32'(first_out_cyc - c0), 17);
        chk("t1_first_sub_lat", 32'(sub0_cyc - c0), 33);
        chk("t1_frame_done_lat", 32'(fd_cyc - c0), 48);
        chk("t1_sb_empty", 32'(sb.size()), 0);
        chk("t1_busy_idle", 32'(busy), 0);

        // T2: three back-to-back frames, din_valid held high
        base = n_out;
        first_out_cyc = -1;
        c0 = cyc;
        repeat (96) drive_beat(1'b0);
        repeat (20) idle();
        chk("t2_out_count", 32'(n_out - base), 96);
        chk("t2_first_add_lat", 32'(first_out_cyc - c0), 17);
        chk("t2_last_done_lat", 32'(fd_cyc - c0), 112);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // T3: random gaps freeze the counters
        base  = n_add;
        base2 = n_sub;
        for (int i = 0; i < 32; i++) begin
            drive_beat(1'b0);
            repeat ($urandom_range(0, 2)) idle();
        end
        repeat (20) idle();
        chk("t3_add_beats", 32'(n_add - base), 16);
        chk("t3_sub_beats", 32'(n_sub - base2), 16);
        chk("t3_drain_contig", 32'(fd_cyc - sub0_cyc), 15);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        chk("t3_busy_idle", 32'(busy), 0);

        // T4: next frame starts the cycle after beat 31
        base2 = n_sub;
        for (int i = 0; i < 32; i++) begin
            drive_beat(1'b0);
            if (i < 31) repeat ($urandom_range(0, 1)) idle();
        end
        repeat (32) drive_beat(1'b0);
        repeat (20) idle();
        chk("t4_sub_beats", 32'(n_sub - base2), 32);
        chk("t4_sb_empty", 32'(sb.size()), 0);

`ifdef STEP0_SOF_EN
        // T5: misaligned start-of-frame at beat 10
        base = n_out;
        repeat (10) drive_beat(1'b0);
        drive_beat(1'b1);
        repeat (31) drive_beat(1'b0);
        repeat (20) idle();
        chk("t5_out_count", 32'(n_out - base), 32);
        chk("t5_sb_empty", 32'(sb.size()), 0);
`endif

        // T6: reset during drain at sub beat 7
        base2     = n_sub;
        fd_before = fd_cyc;
        repeat (32) drive_beat(1'b0);
        repeat (8) idle();
        @(negedge clk);
        #1;
        chk("t6_last_tw", 32'(last_tw), 7);
        do_reset();
        repeat (20) idle();
        chk("t6_sub_beats", 32'(n_sub - base2), 8);
        chk("t6_no_frame_done", 32'(fd_cyc), 32'(fd_before));
        chk("t6_sub_rd_stopped", 32'(sub_rd), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_step0_ctrl
`default_nettype wire
